// File: rtl/phaser_in_rdlvl.sv
// Read-path fine-delay calibration for the input phaser: rewinds the tap,
// sweeps it voting on DQS samples, then parks past the first stable 0->1 edge.
module phaser_in_rdlvl #(
    parameter int TAP_MAX       = 63,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLES       = 4,
    parameter int CENTER_OFFSET = 16
) (
    input  logic       SYSCLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic       SAMPLE,
    input  logic       SAMPLEVALID,
    input  logic       COUNTERLOADEN,
    input  logic [5:0] COUNTERLOADVAL,
    input  logic       COUNTERREADEN,
    output logic [5:0] COUNTERREADVAL,
    output logic       FINEENABLE,
    output logic       FINEINC,
    output logic       FINEOVERFLOW,
    output logic [5:0] EDGETAP,
    output logic       BUSY,
    output logic       DONE,
    output logic       FAIL
);

    typedef enum logic [2:0] {
        S_IDLE, S_REWIND, S_SETTLE, S_SAMPLE, S_EVAL, S_STEP, S_CENTER
    } state_t;

    localparam logic [5:0] TMAX     = 6'(TAP_MAX);
    localparam logic [7:0] SET_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] SMP_LAST = 4'(SAMPLES - 1);
    localparam logic [3:0] SMP_ALL  = 4'(SAMPLES);
    localparam logic [6:0] OFFS     = 7'(CENTER_OFFSET);

    state_t     state, state_n;
    logic [5:0] tap, tap_n;
    logic [7:0] settle_cnt, settle_n;
    logic [3:0] smp_cnt, smp_n;
    logic [3:0] ones_cnt, ones_n;
    logic       seen_low, seen_n;
    logic [5:0] edge_tap, edge_n;
    logic       done, done_n;
    logic       fail, fail_n;
    logic       fine_en, fen_n;
    logic       fine_inc, finc_n;
    logic       fine_ovf, fovf_n;
    logic [5:0] read_val, read_n;

    logic       mv_req, mv_inc;
    logic [6:0] sum;
    logic [5:0] target;

    // Centering target is formed one bit wider so the clamp sees the carry.
    assign sum    = {1'b0, edge_tap} + OFFS;
    assign target = (sum > {1'b0, TMAX}) ? TMAX : sum[5:0];

    always_ff @(posedge SYSCLK) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            tap        <= '0;
            settle_cnt <= '0;
            smp_cnt    <= '0;
            ones_cnt   <= '0;
            seen_low   <= 1'b0;
            edge_tap   <= '0;
            done       <= 1'b0;
            fail       <= 1'b0;
            fine_en    <= 1'b0;
            fine_inc   <= 1'b0;
            fine_ovf   <= 1'b0;
            read_val   <= '0;
        end else begin
            state      <= state_n;
            tap        <= tap_n;
            settle_cnt <= settle_n;
            smp_cnt    <= smp_n;
            ones_cnt   <= ones_n;
            seen_low   <= seen_n;
            edge_tap   <= edge_n;
            done       <= done_n;
            fail       <= fail_n;
            fine_en    <= fen_n;
            fine_inc   <= finc_n;
            fine_ovf   <= fovf_n;
            read_val   <= read_n;
        end
    end

    always_comb begin
        state_n  = state;
        tap_n    = tap;
        settle_n = settle_cnt;
        smp_n    = smp_cnt;
        ones_n   = ones_cnt;
        seen_n   = seen_low;
        edge_n   = edge_tap;
        done_n   = done;
        fail_n   = fail;
        mv_req   = 1'b0;
        mv_inc   = 1'b0;
        fen_n    = 1'b0;
        finc_n   = 1'b0;
        fovf_n   = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (COUNTERLOADEN) tap_n = COUNTERLOADVAL;
                if (START) begin
                    done_n   = 1'b0;
                    fail_n   = 1'b0;
                    seen_n   = 1'b0;
                    edge_n   = '0;
                    settle_n = '0;
                    if (tap_n != '0) begin
                        state_n = S_REWIND;
                        mv_req  = 1'b1;
                    end else begin
                        state_n = S_SETTLE;
                    end
                end
            end
            S_REWIND: begin
                if (tap == '0) begin
                    state_n  = S_SETTLE;
                    settle_n = '0;
                end else begin
                    mv_req = 1'b1;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == SET_LAST) begin
                    state_n  = S_SAMPLE;
                    settle_n = '0;
                    smp_n    = '0;
                    ones_n   = '0;
                end else begin
                    settle_n = settle_cnt + 8'd1;
                end
            end
            S_SAMPLE: begin
                if (SAMPLEVALID) begin
                    smp_n  = smp_cnt + 4'd1;
                    ones_n = ones_cnt + {3'b000, SAMPLE};
                    if (smp_cnt == SMP_LAST) state_n = S_EVAL;
                end
            end
            S_EVAL: begin
                if (ones_cnt == '0) seen_n = 1'b1;
                if (ones_cnt == SMP_ALL && seen_low) begin
                    edge_n  = tap;
                    state_n = S_CENTER;
                end else if (tap == TMAX) begin
                    fail_n  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    state_n = S_STEP;
                end
            end
            S_STEP: begin
                mv_req   = 1'b1;
                mv_inc   = 1'b1;
                state_n  = S_SETTLE;
                settle_n = '0;
            end
            S_CENTER: begin
                if (tap == target) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    mv_req = 1'b1;
                    mv_inc = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Moves apply to the post-load tap so a same-cycle load is honoured.
        if (mv_req) begin
            if (mv_inc ? (tap_n == TMAX) : (tap_n == '0)) begin
                fovf_n = 1'b1;
            end else begin
                fen_n  = 1'b1;
                finc_n = mv_inc;
                tap_n  = mv_inc ? tap_n + 6'd1 : tap_n - 6'd1;
            end
        end

        read_n = COUNTERREADEN ? tap_n : read_val;
    end

    assign COUNTERREADVAL = read_val;
    assign FINEENABLE     = fine_en;
    assign FINEINC        = fine_inc;
    assign FINEOVERFLOW   = fine_ovf;
    assign EDGETAP        = edge_tap;
    assign BUSY           = (state != S_IDLE);
    assign DONE           = done;
    assign FAIL           = fail;

endmodule

// File: doc/phaser_in_rdlvl.md
# phaser_in_rdlvl

Read-path fine-delay calibration controller for the input phaser. It sits in the SYSCLK domain next to the read-capture phaser and ISERDES, and is the receive-side counterpart of the output phaser's write-path tap control. It rewinds the phaser fine-tap counter, then steps the tap through its range while voting on captured DQS samples. When it finds the first stable 0→1 transition, it parks the tap at that edge plus a centering offset. It mirrors the phaser counter load/read interface so software can set and read the tap while the controller is idle.

## Interface
- TAP_MAX, 63: highest fine tap; the tap counter is 6 bits.
- SETTLE_CYCLES, 8: wait cycles after every tap move before sampling (≥1).
- SAMPLES, 4: consecutive valid samples collected per tap (1..15).
- CENTER_OFFSET, 16: taps added to the detected edge for the final position.

Ports:
- SYSCLK  in  1  sole clock; all logic on the rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- START  in  1  one-cycle pulse that begins calibration; honored only in IDLE.
- SAMPLE  in  1  captured DQS level at the current tap.
- SAMPLEVALID  in  1  qualifies SAMPLE.
- COUNTERLOADEN  in  1  loads COUNTERLOADVAL into the tap mirror; honored only in IDLE.
- COUNTERLOADVAL  in  6  tap value to load.
- COUNTERREADEN  in  1  requests a tap readback.
- COUNTERREADVAL  out  6  registered tap readback.
- FINEENABLE  out  1  one-cycle tap-move strobe to the phaser.
- FINEINC  out  1  move direction, valid with FINEENABLE: 1 = increment, 0 = decrement.
- FINEOVERFLOW  out  1  one-cycle pulse on an attempted move past 0 or TAP_MAX.
- EDGETAP  out  6  tap at which the edge was found.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  level; calibration succeeded.
- FAIL  out  1  level; no edge found.

## Operation
- States: IDLE, REWIND, SETTLE, SAMPLE, EVAL, STEP, CENTER.
- The tap mirror `tap` changes on the same edge that registers FINEENABLE=1.
- On reset:
  - all outputs are 0, `tap`=0, state is IDLE;
  - `seen_low`=0, all counters are 0.
- IDLE:
  - START clears DONE, FAIL, `seen_low` and EDGETAP.
  - Next state is REWIND if `tap`≠0, otherwise SETTLE.
  - COUNTERLOADEN sets `tap`=COUNTERLOADVAL and issues no FINEENABLE.
  - If START and COUNTERLOADEN arrive together, the load happens first, then START is evaluated on the loaded value.
- REWIND: one decrement pulse per cycle until `tap`=0, then SETTLE.
- SETTLE: wait SETTLE_CYCLES cycles; SAMPLEVALID is ignored.
- SAMPLE:
  - count valid samples and the ones among them;
  - after SAMPLES valid samples, go to EVAL;
  - cycles with no valid sample are waited out indefinitely, with no timeout.
- EVAL (one cycle):
  - vote = 1 if ones=SAMPLES, 0 if ones=0, otherwise unstable.
  - Vote 0: set `seen_low`.
  - Vote 1 with `seen_low` set: EDGETAP←`tap`, go to CENTER.
  - Otherwise, if `tap`=TAP_MAX: assert FAIL, go to IDLE.
  - Otherwise: go to STEP.
  - An unstable vote never sets or clears `seen_low`.
- STEP: one increment pulse, then SETTLE.
- CENTER:
  - target = min(EDGETAP+CENTER_OFFSET, TAP_MAX), computed 7 bits wide and then clamped;
  - one increment pulse per cycle until `tap`=target;
  - then assert DONE and go to IDLE.
- Saturation: any move request at a limit issues no FINEENABLE and pulses FINEOVERFLOW for one cycle. By construction the state machine never requests such a move.
- Readback: COUNTERREADEN high at edge N puts `tap` (as registered after edge N) on COUNTERREADVAL at edge N+1. COUNTERREADVAL holds otherwise and is valid in any state.
- START, or COUNTERLOADEN while BUSY: ignored, with no side effect.
- RST_N low in any state: IDLE on the next edge, `tap`=0, FINEENABLE=0. Reset does not issue pulses to rewind the physical phaser.

## Timing
- START at edge N: BUSY=1 at N+1. The first FINEENABLE is at N+1 when rewinding; otherwise SETTLE starts at N+1.
- Per-tap cost with continuous SAMPLEVALID: 1 (STEP) + SETTLE_CYCLES + SAMPLES + 1 (EVAL) cycles.
- DONE or FAIL rises on the same edge on which BUSY falls.
- FINEENABLE is never high on two consecutive cycles with different FINEINC values.

## Test plan
- Reset:
  - Stimulus: hold RST_N low for 3 cycles.
  - Required: every output is 0 and COUNTERREADVAL=0 after a read request.
- Edge at tap 20:
  - Stimulus: defaults, SAMPLE = (tap≥20), SAMPLEVALID always 1, START.
  - Required: 0 decrement pulses, 36 increment pulses in total, EDGETAP=20, final tap 36, DONE=1, FAIL=0.
- No low seen:
  - Stimulus: SAMPLE always 1, START.
  - Required: 63 step pulses, FAIL=1 at tap 63, DONE=0, EDGETAP=0, no FINEOVERFLOW.
- Clamp and rewind:
  - Stimulus: COUNTERLOADVAL=40 with COUNTERLOADEN in IDLE, then START with SAMPLE = (tap≥55).
  - Required: 40 consecutive decrement pulses, EDGETAP=55, final tap 63 (clamped), DONE=1.
- Unstable taps:
  - Stimulus: SAMPLE alternating 0/1 at taps 0–9, 0 at taps 10–14, 1 from tap 15.
  - Required: EDGETAP=15. Separately, SAMPLE alternating at every tap gives FAIL.
- Mid-operation events:
  - Stimulus: a START pulse and a COUNTERLOADEN (value 5) during SETTLE; later, RST_N low during CENTER.
  - Required: both ignored (no change to tap or state). After the reset, the next edge shows state IDLE, tap 0, BUSY=0, and no further FINEENABLE.
